// File: rtl/bsg_dff_negedge_capture_credit.sv
// bsg_dff_negedge_capture_credit
//
// Posedge-domain receiver for data launched by a negedge flop stage on the
// same clock. The launch stage has only half a cycle, so it cannot react to
// a same-cycle ready. Flow control is credit based instead: the source starts
// with els_p credits and spends one per v_i. This block captures v_i/data_i
// on posedge clk_i into an els_p-entry FIFO, presents the head with a
// valid/yumi handshake and returns one credit_o pulse per dequeue.
//
// The supported range of els_p is 2..8.
//
// Optional feature, enabled by defining BSG_DFF_NEGEDGE_CAPTURE_PARITY_EN:
//   parity_i     : even parity over data_i, launched with data_i
//   parity_err_o : sticky flag, set when an accepted enqueue has bad parity
// The default build (macro undefined) has neither port nor any parity logic.

module bsg_dff_negedge_capture_credit #(
  parameter int width_p = 64,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,

  // Negedge launch side.
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,

  // Consumer side.
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i,

  // Credit return and error reporting.
  output logic               credit_o,
  output logic               overflow_o
`ifdef BSG_DFF_NEGEDGE_CAPTURE_PARITY_EN
  ,input  logic              parity_i
  ,output logic              parity_err_o
`endif
);

  localparam int ptr_w = $clog2(els_p);
  localparam int cnt_w = $clog2(els_p + 1);

  localparam logic [ptr_w-1:0] last_ptr = ptr_w'(els_p - 1);
  localparam logic [cnt_w-1:0] full_cnt = cnt_w'(els_p);
  localparam logic [cnt_w-1:0] one_cnt  = cnt_w'(1);

  // Advance a slot pointer, wrapping from els_p-1 back to 0. Needed because
  // els_p does not have to be a power of two.
  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    return (p == last_ptr) ? '0 : p + 1'b1;
  endfunction

  // Storage and bookkeeping.
  logic [width_p-1:0] mem [els_p];
  logic [ptr_w-1:0]   wptr;
  logic [ptr_w-1:0]   rptr;
  logic [cnt_w-1:0]   count;
  logic [cnt_w-1:0]   count_n;

  // Handshake decode.
  logic empty;
  logic full;
  logic deq;
  logic enq;
  logic ovf_set;

  assign empty = (count == '0);
  assign full  = (count == full_cnt);

  // A yumi on an empty buffer is illegal. Masking it here leaves the state
  // unchanged if it happens anyway.
  assign deq = yumi_i & ~empty;

  // A full buffer still accepts a write when the head leaves in the same
  // cycle, because the slot being freed is reused.
  assign enq = v_i & (~full | deq);

  // The source sent data with no credit left. Drop the write and flag it.
  assign ovf_set = v_i & full & ~deq;

  // Occupancy: +1 on enqueue only, -1 on dequeue only, hold otherwise.
  always_comb begin
    // NOTE: default assignment first so every path writes count_n and no latch is inferred.
    count_n = count;
    unique case ({enq, deq})
      2'b10:   count_n = count + one_cnt;
      2'b01:   count_n = count - one_cnt;
      default: count_n = count;
    endcase
  end

  // Pointers, occupancy, credit return and the sticky overflow flag.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      credit_o   <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (enq) wptr <= ptr_inc(wptr);
      if (deq) rptr <= ptr_inc(rptr);
      count    <= count_n;
      credit_o <= deq;
      if (ovf_set) overflow_o <= 1'b1;
    end
  end

  // Payload storage, written at the write pointer on each accepted enqueue.
  always_ff @(posedge clk_i) begin
    // NOTE: the payload array is not reset; count gates every read, so stale contents are never seen.
    if (enq) mem[wptr] <= data_i;
  end

  // Head of the FIFO. The output is forced to zero while the buffer is empty,
  // and data_i never reaches data_o without passing through a register.
  assign v_o    = ~empty;
  assign data_o = empty ? '0 : mem[rptr];

`ifdef BSG_DFF_NEGEDGE_CAPTURE_PARITY_EN
  logic parity_bad;

  // Even parity: the XOR of data_i and parity_i together must be zero.
  assign parity_bad = (^data_i) ^ parity_i;

  // Sticky parity error. The entry is still enqueued and credited normally.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      parity_err_o <= 1'b0;
    end else if (enq && parity_bad) begin
      parity_err_o <= 1'b1;
    end
  end
`endif

`ifndef SYNTHESIS
  // The consumer must not dequeue from an empty buffer.
  yumi_on_empty_a : assert property (@(posedge clk_i) disable iff (reset_i)
                                     !(yumi_i && !v_o))
    else $error("bsg_dff_negedge_capture_credit: yumi_i asserted while v_o=0");
`endif

endmodule

// File: tb/tb_bsg_dff_negedge_capture_credit.sv
// Self-checking bench for bsg_dff_negedge_capture_credit (width_p=64, els_p=2).
// Inputs change on the negedge, as the launch stage would drive them. Outputs
// are sampled 1 ns after the posedge. A queue-based reference model holds
// the expected FIFO contents, the expected credit pulse and the expected
// overflow flag.

module tb_bsg_dff_negedge_capture_credit;

  localparam int W   = 64;
  localparam int ELS = 2;

  logic         clk_i;
  logic         reset_i;
  logic         v_i;
  logic [W-1:0] data_i;
  logic         v_o;
  logic [W-1:0] data_o;
  logic         yumi_i;
  logic         credit_o;
  logic         overflow_o;
`ifdef BSG_DFF_NEGEDGE_CAPTURE_PARITY_EN
  logic         parity_i;
  logic         parity_err_o;
  logic         par_flip;
`endif

  int checks;
  int errors;

  // Reference model.
  logic [W-1:0] sb[$];
  logic         exp_credit;
  logic         exp_ovf;

  bsg_dff_negedge_capture_credit #(.width_p(W), .els_p(ELS)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .v_i        (v_i),
    .data_i     (data_i),
    .v_o        (v_o),
    .data_o     (data_o),
    .yumi_i     (yumi_i),
    .credit_o   (credit_o),
    .overflow_o (overflow_o)
`ifdef BSG_DFF_NEGEDGE_CAPTURE_PARITY_EN
    ,.parity_i     (parity_i)
    ,.parity_err_o (parity_err_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // One clock of stimulus: drive on the negedge, update the model at the
  // posedge, return 1 ns after the posedge with the inputs idled again.
  task automatic drive(input logic v, input logic [W-1:0] d, input logic y);
    logic full;
    logic deq;
    @(negedge clk_i);
    v_i    = v;
    data_i = d;
    yumi_i = y;
`ifdef BSG_DFF_NEGEDGE_CAPTURE_PARITY_EN
    parity_i = (^d) ^ par_flip;
`endif
    @(posedge clk_i);
    full = (sb.size() == ELS);
    deq  = y && (sb.size() != 0);
    if (deq) void'(sb.pop_front());
    if (v && (!full || deq)) sb.push_back(d);
    else if (v) exp_ovf = 1'b1;
    exp_credit = deq;
    #1;
    v_i    = 1'b0;
    data_i = '0;
    yumi_i = 1'b0;
  endtask

  // Reset asserted in the middle of a cycle and released on the negedge.
  task automatic pulse_reset();
    #2;
    reset_i = 1'b1;
    sb.delete();
    exp_credit = 1'b0;
    exp_ovf    = 1'b0;
    #1;
    checks++;
    if (v_o !== 1'b0) begin
      errors++; $display("FAIL reset_v_o: got %b want 0", v_o);
    end
    checks++;
    if (credit_o !== 1'b0) begin
      errors++; $display("FAIL reset_credit_o: got %b want 0", credit_o);
    end
    checks++;
    if (overflow_o !== 1'b0) begin
      errors++; $display("FAIL reset_overflow_o: got %b want 0", overflow_o);
    end
    @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    pulse_reset();
    checks++;
    if (data_o !== '0) begin
      errors++; $display("FAIL reset_data_o: got %h want 0", data_o);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, '0, 1'b0);
      checks++;
      if (v_o !== 1'b0 || credit_o !== 1'b0 || overflow_o !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_reset[%0d]: got v=%b credit=%b ovf=%b want 000",
                 i, v_o, credit_o, overflow_o);
      end
    end
  endtask

  task automatic test_single();
    drive(1'b1, 64'hDEAD_BEEF_0123_4567, 1'b0);
    checks++;
    if (v_o !== 1'b1 || data_o !== sb[0]) begin
      errors++; $display("FAIL single_out: got v=%b d=%h want v=1 d=%h", v_o, data_o, sb[0]);
    end
    checks++;
    if (credit_o !== 1'b0) begin
      errors++; $display("FAIL single_no_credit: got %b want 0", credit_o);
    end
    drive(1'b0, '0, 1'b1);
    checks++;
    if (credit_o !== 1'b1 || v_o !== 1'b0) begin
      errors++; $display("FAIL single_deq: got credit=%b v=%b want credit=1 v=0", credit_o, v_o);
    end
    drive(1'b0, '0, 1'b0);
    checks++;
    if (credit_o !== 1'b0) begin
      errors++; $display("FAIL single_credit_width: got %b want 0", credit_o);
    end
  endtask

  task automatic test_fill_drain();
    drive(1'b1, 64'h1, 1'b0);
    drive(1'b1, 64'h2, 1'b0);
    checks++;
    if (v_o !== 1'b1 || data_o !== 64'h1 || sb.size() != 2) begin
      errors++; $display("FAIL fill_head: got v=%b d=%h want v=1 d=1", v_o, data_o);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (data_o !== sb[0]) begin
        errors++; $display("FAIL drain_data[%0d]: got %h want %h", i, data_o, sb[0]);
      end
      drive(1'b0, '0, 1'b1);
      checks++;
      if (credit_o !== 1'b1) begin
        errors++; $display("FAIL drain_credit[%0d]: got %b want 1", i, credit_o);
      end
    end
    checks++;
    if (v_o !== 1'b0 || overflow_o !== 1'b0) begin
      errors++; $display("FAIL drain_end: got v=%b ovf=%b want 00", v_o, overflow_o);
    end
    drive(1'b0, '0, 1'b0);
  endtask

  task automatic test_full_simul();
    drive(1'b1, 64'hA, 1'b0);
    drive(1'b1, 64'hB, 1'b0);
    checks++;
    if (data_o !== 64'hA) begin
      errors++; $display("FAIL simul_head: got %h want a", data_o);
    end
    drive(1'b1, 64'hC, 1'b1);
    checks++;
    if (overflow_o !== 1'b0 || credit_o !== 1'b1 || v_o !== 1'b1) begin
      errors++; $display("FAIL simul_flags: got ovf=%b credit=%b v=%b want 011",
                         overflow_o, credit_o, v_o);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (data_o !== sb[0]) begin
        errors++; $display("FAIL simul_order[%0d]: got %h want %h", i, data_o, sb[0]);
      end
      drive(1'b0, '0, 1'b1);
    end
    checks++;
    if (v_o !== 1'b0 || overflow_o !== 1'b0 || sb.size() != 0) begin
      errors++; $display("FAIL simul_end: got v=%b ovf=%b want 00", v_o, overflow_o);
    end
  endtask

  // Random traffic from a source that honours its credits.
  task automatic test_back_to_back();
    logic         v;
    logic         y;
    logic [W-1:0] d;
    for (int i = 0; i < 40; i++) begin
      y = (sb.size() != 0) && ($urandom_range(0, 3) != 0);
      v = ((sb.size() < ELS) || y) && ($urandom_range(0, 3) != 0);
      d = {$urandom, $urandom};
      if (y) begin
        checks++;
        if (data_o !== sb[0]) begin
          errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, data_o, sb[0]);
        end
      end
      drive(v, d, y);
      checks++;
      if (credit_o !== exp_credit || v_o !== (sb.size() != 0)) begin
        errors++; $display("FAIL b2b_flags[%0d]: got credit=%b v=%b want credit=%b v=%b",
                           i, credit_o, v_o, exp_credit, (sb.size() != 0));
      end
    end
    while (sb.size() != 0) begin
      checks++;
      if (data_o !== sb[0]) begin
        errors++; $display("FAIL b2b_drain: got %h want %h", data_o, sb[0]);
      end
      drive(1'b0, '0, 1'b1);
    end
    checks++;
    if (overflow_o !== 1'b0 || v_o !== 1'b0) begin
      errors++; $display("FAIL b2b_end: got ovf=%b v=%b want 00", overflow_o, v_o);
    end
  endtask

  task automatic test_overflow();
    drive(1'b1, 64'hD0, 1'b0);
    drive(1'b1, 64'hD1, 1'b0);
    drive(1'b1, 64'hF, 1'b0);
    checks++;
    if (overflow_o !== exp_ovf || exp_ovf !== 1'b1) begin
      errors++; $display("FAIL overflow_set: got %b want 1", overflow_o);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (data_o !== sb[0]) begin
        errors++; $display("FAIL overflow_drain[%0d]: got %h want %h", i, data_o, sb[0]);
      end
      drive(1'b0, '0, 1'b1);
    end
    drive(1'b0, '0, 1'b0);
    checks++;
    if (v_o !== 1'b0 || overflow_o !== 1'b1) begin
      errors++; $display("FAIL overflow_sticky: got v=%b ovf=%b want v=0 ovf=1", v_o, overflow_o);
    end
  endtask

  task automatic test_reset_midop();
    drive(1'b1, 64'h55, 1'b0);
    drive(1'b1, 64'h66, 1'b0);
    pulse_reset();
    drive(1'b0, '0, 1'b0);
    checks++;
    if (v_o !== 1'b0 || credit_o !== 1'b0 || overflow_o !== 1'b0) begin
      errors++; $display("FAIL midop_after: got v=%b credit=%b ovf=%b want 000",
                         v_o, credit_o, overflow_o);
    end
    drive(1'b1, 64'h77, 1'b0);
    checks++;
    if (v_o !== 1'b1 || data_o !== sb[0]) begin
      errors++; $display("FAIL midop_restart: got v=%b d=%h want v=1 d=%h", v_o, data_o, sb[0]);
    end
    drive(1'b0, '0, 1'b1);
  endtask

`ifdef BSG_DFF_NEGEDGE_CAPTURE_PARITY_EN
  task automatic test_parity();
    checks++;
    if (parity_err_o !== 1'b0) begin
      errors++; $display("FAIL parity_clean: got %b want 0", parity_err_o);
    end
    par_flip = 1'b1;
    drive(1'b1, 64'h1, 1'b0);
    par_flip = 1'b0;
    checks++;
    if (parity_err_o !== 1'b1 || v_o !== 1'b1 || data_o !== 64'h1) begin
      errors++; $display("FAIL parity_err: got err=%b v=%b d=%h want err=1 v=1 d=1",
                         parity_err_o, v_o, data_o);
    end
    drive(1'b0, '0, 1'b1);
    checks++;
    if (credit_o !== 1'b1 || parity_err_o !== 1'b1) begin
      errors++; $display("FAIL parity_credit: got credit=%b err=%b want 11", credit_o, parity_err_o);
    end
  endtask
`endif

  initial begin
    checks     = 0;
    errors     = 0;
    exp_credit = 1'b0;
    exp_ovf    = 1'b0;
    reset_i    = 1'b0;
    v_i        = 1'b0;
    data_i     = '0;
    yumi_i     = 1'b0;
`ifdef BSG_DFF_NEGEDGE_CAPTURE_PARITY_EN
    par_flip   = 1'b0;
    parity_i   = 1'b0;
`endif
    test_reset();
    test_single();
    test_fill_drain();
    test_full_simul();
    test_back_to_back();
    test_overflow();
    test_reset_midop();
`ifdef BSG_DFF_NEGEDGE_CAPTURE_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
